// File: rtl/lstm_gate_mac_if.sv
// Signal bundle for lstm_gate_mac: x-buffer load, pass control, results,
// and the read port of the downstream-facing weight RAM.
interface lstm_gate_mac_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
);
  logic              start;
  logic              x_wr_en;
  logic [4:0]        x_wr_idx;
  logic [DATA_W-1:0] x_wr_data;
  logic              mem_ce0;
  logic [ADDR_W-1:0] mem_addr0;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] y_data;
  logic [4:0]        y_row;
  logic              y_valid;
  logic              busy;
  logic              done;

  modport slave (
    input  start, x_wr_en, x_wr_idx, x_wr_data, mem_rdata,
    output mem_ce0, mem_addr0, y_data, y_row, y_valid, busy, done
  );

  modport master (
    output start, x_wr_en, x_wr_idx, x_wr_data, mem_rdata,
    input  mem_ce0, mem_addr0, y_data, y_row, y_valid, busy, done
  );
endinterface

// File: rtl/lstm_gate_mac.sv
// Streaming weight-row x input-vector MAC producing one gate pre-activation per row.
// Optional output saturation: define LSTM_GATE_MAC_SAT_EN (default build wraps).
module lstm_gate_mac #(
  parameter int DATA_W   = 16,
  parameter int FRAC     = 8,
  parameter int VEC_LEN  = 20,
  parameter int NUM_ROWS = 20,
  parameter int ADDR_W   = 9,
  parameter int ACC_W    = 40
) (
  input  logic           clk,
  input  logic           reset,
  lstm_gate_mac_if.slave bus
);

  localparam logic [4:0] COL_LAST = 5'(VEC_LEN - 1);
  localparam logic [4:0] ROW_LAST = 5'(NUM_ROWS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN1, DRAIN2} state_t;

  typedef struct packed {
    logic       valid;
    logic       last;
    logic [4:0] col;
    logic [4:0] row;
  } tag_t;

  state_t state, state_next;
  logic   accept, advance, last_issue;

  logic [4:0]        col, row;
  logic [ADDR_W-1:0] addr;
  logic              ce0, busy_q, done_q, y_valid_q;
  logic [DATA_W-1:0] y_data_q;
  logic [4:0]        y_row_q;
  tag_t              tag_issue, tag1, tag2;

  logic signed [DATA_W-1:0]   x_buf [VEC_LEN];
  logic signed [DATA_W-1:0]   w_s, x_s;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc, acc_base, prod_ext, sum, shifted;
  logic [DATA_W-1:0]          y_fmt;

  assign last_issue = (col == COL_LAST) && (row == ROW_LAST);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE:    if (bus.start) begin
                 state_next = RUN;
                 accept     = 1'b1;
               end
      RUN:     if (last_issue) state_next = DRAIN1;
               else            advance    = 1'b1;
      DRAIN1:  state_next = DRAIN2;
      DRAIN2:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Issue side: col/row/addr always describe the address currently on the bus.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      col    <= '0;
      row    <= '0;
      addr   <= '0;
      ce0    <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      if (accept) begin
        col    <= '0;
        row    <= '0;
        addr   <= '0;
        ce0    <= 1'b1;
        busy_q <= 1'b1;
      end else if (advance) begin
        addr <= addr + ADDR_W'(1);
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + 5'd1;
        end else begin
          col <= col + 5'd1;
        end
      end
      if (state == DRAIN1) ce0    <= 1'b0;
      if (state == DRAIN2) busy_q <= 1'b0;
    end
  end

  assign tag_issue = '{valid: (state == RUN), last: (col == COL_LAST), col: col, row: row};

  // Tags move in lockstep with the RAM's ce0-gated two-register read path;
  // once ce0 drops the final tag is consumed once and then invalidated.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tag1 <= '0;
      tag2 <= '0;
    end else if (ce0) begin
      tag1 <= tag_issue;
      tag2 <= tag1;
    end else begin
      tag1.valid <= 1'b0;
      tag2.valid <= 1'b0;
    end
  end

  // NOTE: the x register file is deliberately left out of reset; it is plain storage.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.x_wr_en && (32'(bus.x_wr_idx) < VEC_LEN))
      x_buf[bus.x_wr_idx] <= bus.x_wr_data;
  end

  always_comb begin
    w_s      = bus.mem_rdata;
    x_s      = x_buf[tag2.col];
    prod     = (2*DATA_W)'(w_s) * (2*DATA_W)'(x_s);
    prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    acc_base = (tag2.col == 5'd0) ? '0 : acc;
    sum      = acc_base + prod_ext;
    shifted  = sum >>> FRAC;
`ifdef LSTM_GATE_MAC_SAT_EN
    if (shifted > $signed({{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}}))
      y_fmt = {1'b0, {(DATA_W-1){1'b1}}};
    else if (shifted < $signed({{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}}))
      y_fmt = {1'b1, {(DATA_W-1){1'b0}}};
    else
      y_fmt = DATA_W'(shifted);
`else
    y_fmt = DATA_W'(shifted);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc       <= '0;
      y_data_q  <= '0;
      y_row_q   <= '0;
      y_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      y_valid_q <= 1'b0;
      done_q    <= 1'b0;
      if (tag2.valid) begin
        acc <= sum;
        if (tag2.last) begin
          y_data_q  <= y_fmt;
          y_row_q   <= tag2.row;
          y_valid_q <= 1'b1;
          done_q    <= (tag2.row == ROW_LAST);
        end
      end
    end
  end

  assign bus.mem_ce0   = ce0;
  assign bus.mem_addr0 = addr;
  assign bus.y_data    = y_data_q;
  assign bus.y_row     = y_row_q;
  assign bus.y_valid   = y_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_lstm_gate_mac.sv
// Directed bench for lstm_gate_mac with a 2-edge ce0-gated RAM model in front of it.
module tb_lstm_gate_mac;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 9;
  localparam int VEC_LEN  = 20;
  localparam int NUM_ROWS = 20;
  localparam int N        = VEC_LEN * NUM_ROWS;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lstm_gate_mac_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  lstm_gate_mac #(
    .DATA_W(DATA_W), .FRAC(8), .VEC_LEN(VEC_LEN), .NUM_ROWS(NUM_ROWS),
    .ADDR_W(ADDR_W), .ACC_W(40)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [DATA_W-1:0] ram [2**ADDR_W];
  logic [DATA_W-1:0] temp_out = '0;
  logic [DATA_W-1:0] wout_all = '0;
  always @(posedge clk) begin
    if (bus.mem_ce0) begin
      temp_out <= ram[bus.mem_addr0];
      wout_all <= temp_out;
    end
  end
  assign bus.mem_rdata = wout_all;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int   edge_idx = 0;
  int   e0 = 0;
  int   rel;
  bit   armed = 1'b0;
  logic [DATA_W-1:0] got_y [NUM_ROWS];
  logic [DATA_W-1:0] exp_y [NUM_ROWS];
  int   n_res, total_res, first_e, done_cnt, done_e, addr_bad;
  logic done_busy, done_valid, ce0_drain, ce0_after, busy_e0;

  always @(posedge clk) edge_idx <= edge_idx + 1;

  always @(negedge clk) begin
    if (armed) begin
      rel = edge_idx - e0;
      if (rel == 0) busy_e0 = bus.busy;
      if (rel < N && !(bus.mem_ce0 && bus.mem_addr0 == ADDR_W'(rel))) addr_bad++;
      if (rel == N)     ce0_drain = bus.mem_ce0;
      if (rel == N + 1) ce0_after = bus.mem_ce0;
      if (bus.y_valid) begin
        if (n_res == 0) first_e = rel;
        n_res++;
        total_res++;
        if (int'(bus.y_row) < NUM_ROWS) got_y[bus.y_row] = bus.y_data;
      end
      if (bus.done) begin
        done_cnt++;
        done_e     = rel;
        done_busy  = bus.busy;
        done_valid = bus.y_valid;
      end
    end
  end

  task automatic clear_stats();
    n_res = 0; first_e = -1; done_cnt = 0; done_e = -1; addr_bad = 0;
    done_busy = 1'bx; done_valid = 1'bx; ce0_drain = 1'bx; ce0_after = 1'bx; busy_e0 = 1'bx;
    for (int r = 0; r < NUM_ROWS; r++) got_y[r] = 16'hdead;
  endtask

  task automatic fill_ram(input logic [15:0] v);
    for (int a = 0; a < 2**ADDR_W; a++) ram[a] = v;
  endtask

  task automatic set_row(input int r, input logic [15:0] v);
    for (int c = 0; c < VEC_LEN; c++) ram[r*VEC_LEN + c] = v;
  endtask

  task automatic load_x(input logic [15:0] v);
    for (int i = 0; i < VEC_LEN; i++) begin
      @(negedge clk);
      bus.x_wr_en = 1'b1; bus.x_wr_idx = 5'(i); bus.x_wr_data = v;
    end
    @(negedge clk);
    bus.x_wr_en = 1'b0;
  endtask

  // Caller must be between a negedge and the next posedge.
  task automatic begin_pass();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    clear_stats();
    e0 = edge_idx;
    armed = 1'b1;
    bus.start = 1'b0;
  endtask

  task automatic start_pass();
    @(negedge clk);
    begin_pass();
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_done_seen"}, done_cnt > 0, 1);
  endtask

  task automatic check_rows(input string tag);
    check({tag, "_nres"}, n_res, NUM_ROWS);
    for (int r = 0; r < NUM_ROWS; r++)
      check($sformatf("%s_row%0d", tag, r), got_y[r], exp_y[r]);
  endtask

  task automatic set_exp_all(input logic [15:0] v);
    for (int r = 0; r < NUM_ROWS; r++) exp_y[r] = v;
  endtask

  initial begin
    bus.start = 1'b0; bus.x_wr_en = 1'b0; bus.x_wr_idx = '0; bus.x_wr_data = '0;
    clear_stats();
    total_res = 0;
    fill_ram(16'h0000);

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ce0",     bus.mem_ce0,   0);
    check("rst_addr",    bus.mem_addr0, 0);
    check("rst_y_data",  bus.y_data,    0);
    check("rst_y_row",   bus.y_row,     0);
    check("rst_y_valid", bus.y_valid,   0);
    check("rst_busy",    bus.busy,      0);
    check("rst_done",    bus.done,      0);
    reset = 1'b1;

    // All-ones pass: 20 * 1.0 * 1.0 = 20.0 per row, plus latency checks
    fill_ram(16'h0100);
    load_x(16'h0100);
    start_pass();
    wait_done("basic");
    set_exp_all(16'h1400);
    check_rows("basic");
    check("basic_busy_e0",    busy_e0,    1);
    check("basic_first_e",    first_e,    22);
    check("basic_done_e",     done_e,     402);
    check("basic_done_valid", done_valid, 1);
    check("basic_done_busy",  done_busy,  0);
    check("basic_addr_seq",   addr_bad,   0);
    check("basic_ce0_drain",  ce0_drain,  1);
    check("basic_ce0_off",    ce0_after,  0);

    // Negative weights on row 3 only: -0.5 * 2.0 * 20 = -20.0
    fill_ram(16'h0000);
    set_row(3, 16'hFF80);
    load_x(16'h0200);
    start_pass();
    wait_done("neg");
    set_exp_all(16'h0000);
    exp_y[3] = 16'hEC00;
    check_rows("neg");

    // Large values: saturation vs wrap, plus floor of a negative shift
    fill_ram(16'h0000);
    set_row(0, 16'h7FFF);
    ram[1*VEC_LEN] = 16'hFFFF;
    ram[2*VEC_LEN] = 16'h0001;
    set_row(4, 16'h8000);
    load_x(16'h7FFF);
    start_pass();
    wait_done("big");
    set_exp_all(16'h0000);
`ifdef LSTM_GATE_MAC_SAT_EN
    exp_y[0] = 16'h7FFF;
    exp_y[4] = 16'h8000;
`else
    exp_y[0] = 16'hEC00;
    exp_y[4] = 16'h0A00;
`endif
    exp_y[1] = 16'hFF80;
    exp_y[2] = 16'h007F;
    check_rows("big");

    // start / x_wr_en during a pass are ignored
    fill_ram(16'h0100);
    load_x(16'h0100);
    start_pass();
    repeat (50) @(negedge clk);
    bus.start = 1'b1; bus.x_wr_en = 1'b1; bus.x_wr_idx = 5'd0; bus.x_wr_data = 16'h7FFF;
    repeat (3) @(negedge clk);
    bus.start = 1'b0; bus.x_wr_en = 1'b0;
    wait_done("busy_ign");
    set_exp_all(16'h1400);
    check_rows("busy_ign");
    check("busy_ign_addr_seq", addr_bad, 0);
    repeat (10) @(negedge clk);
    check("busy_ign_done_cnt", done_cnt, 1);

    // Reset at E100 aborts the pass; rows 0..3 completed before it
    start_pass();
    repeat (100) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ce0",  bus.mem_ce0, 0);
    check("abort_busy", bus.busy,    0);
    reset = 1'b1;
    check("abort_nres_pre", n_res, 4);
    repeat (400) @(negedge clk);
    check("abort_nres_post", n_res,    4);
    check("abort_no_done",   done_cnt, 0);
    start_pass();
    wait_done("after_abort");
    check_rows("after_abort");
    check("after_abort_addr_seq", addr_bad, 0);

    // Back-to-back passes: start the cycle after done
    total_res = 0;
    start_pass();
    wait_done("b2b_a");
    check_rows("b2b_a");
    begin_pass();
    wait_done("b2b_b");
    check_rows("b2b_b");
    check("b2b_first_e",  first_e,   22);
    check("b2b_total",    total_res, 2*NUM_ROWS);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lstm_gate_mac.md
# lstm_gate_mac

Streaming matrix-vector engine directly downstream of the single-port weight RAM (`memory`). It drives the RAM read port (`ce0`/`addr0`) and consumes `wout_all`. For each of `NUM_ROWS` rows it forms the signed fixed-point dot product of one weight row with a locally buffered input vector and emits one gate pre-activation per row. The block accounts for the RAM's 2-edge, `ce0`-gated read pipeline.

## Interface
- `DATA_W`, default 16: weight/input/output width, signed two's complement
- `FRAC`, default 8: fractional bits (Q7.8 at defaults)
- `VEC_LEN`, default 20: elements per row (columns)
- `NUM_ROWS`, default 20: rows per pass; `VEC_LEN*NUM_ROWS` ≤ RAM depth
- `ADDR_W`, default 9: RAM address width
- `ACC_W`, default 40: accumulator width, signed
- `clk`, in, 1: clock, all logic on rising edge
- `reset`, in, 1: synchronous, active-low
- `start`, in, 1: begin pass; sampled only in IDLE
- `x_wr_en`, in, 1: write one input-vector element; ignored unless IDLE
- `x_wr_idx`, in, 5: element index, `0..VEC_LEN-1`; out-of-range writes are dropped
- `x_wr_data`, in, DATA_W: element value
- `mem_ce0`, out, 1: RAM read enable, registered
- `mem_addr0`, out, ADDR_W: RAM read address, registered, value `row*VEC_LEN+col`
- `mem_rdata`, in, DATA_W: RAM `wout_all`
- `y_data`, out, DATA_W: row result
- `y_row`, out, 5: row index of `y_data`
- `y_valid`, out, 1: one-cycle pulse per row
- `busy`, out, 1: high from the `start` acceptance edge until `done`
- `done`, out, 1: one-cycle pulse coincident with the last `y_valid`

## Operation
- Input buffer: `VEC_LEN` × DATA_W register file, written in IDLE only. It is not cleared by reset.
- FSM states:
  - IDLE: waits for `start`.
  - RUN: issues one address per cycle, N = `VEC_LEN*NUM_ROWS` cycles.
  - DRAIN: 2 cycles, `mem_ce0` held high, address held at the last value.
  - Returns to IDLE.
- Issue counters: `col` runs 0..VEC_LEN-1 and wraps; `row` increments on each wrap. The address is a separate incrementing counter with no multiplier.
- Tag pipeline: a 2-stage shift of {valid, col, last_col, row} advances only on edges where `mem_ce0`=1, mirroring the RAM's `tempOut`→`wout_all` behaviour. The stage-2 tag qualifies `mem_rdata`.
- MAC: `prod` = `mem_rdata * x[col_tag]` is a signed 2·DATA_W product, sign-extended to ACC_W.
  - When col_tag=0, `acc <= prod`.
  - Otherwise, `acc <= acc + prod`.
- Row end (last_col tag): `y_data <= fmt((acc+prod) >>> FRAC)`, `y_row <= row_tag`, `y_valid <= 1`. The shift is an arithmetic floor, with no rounding.
- `start` while busy is ignored. `x_wr_en` while busy is ignored.
- Reset low at any edge:
  - State goes to IDLE.
  - Counters, tags and acc are cleared.
  - All outputs go to 0, including `mem_ce0`.
  - Partial results are discarded and no `done` is produced.

## Timing
- Let E0 be the edge sampling `start`=1 in IDLE. At E0, `busy`=1, `mem_ce0`=1 and `mem_addr0`=0.
- Address k is on the bus after edge Ek, for k=0..N-1.
- The RAM captures address k at E(k+1) and presents it on `wout_all` after E(k+2). The MAC consumes it at E(k+3).
- Row r result: `y_valid` is high in the cycle after E(r·VEC_LEN+VEC_LEN+2).
- Last row: `y_valid`, `done` high and `busy` low after E(N+2). `mem_ce0` drops at E(N+1).
- Throughput: one weight per cycle, with no bubbles between rows. A new `start` is accepted the cycle after `done`.
- Reset values: `mem_ce0`=0, `mem_addr0`=0, `y_data`=0, `y_row`=0, `y_valid`=0, `busy`=0, `done`=0.

## Configuration
- `LSTM_GATE_MAC_SAT_EN`:
  - Defined: `fmt` saturates the shifted accumulator to [−2^(DATA_W−1), 2^(DATA_W−1)−1], i.e. 0x8000 / 0x7FFF.
  - Undefined: `fmt` keeps the low DATA_W bits (two's-complement wrap).
  - The accumulator itself never saturates in either mode.

## Test plan
- Reset, then pulse `start` with all x=0x0100 (1.0) and RAM row r holding all 0x0100 → 20 `y_valid` pulses with `y_data`=0x1400 (20.0). With defaults, the first pulse follows E22, `done` follows E402, and `mem_addr0` runs 0..399 contiguously.
- Row 3 weights = 0xFF80 (−0.5), x=0x0200 (2.0), all other rows 0 → row 3 `y_data`=0xEC00 (−20.0), all other rows 0x0000.
- Row 0 weights = 0x7FFF, x=0x7FFF →
  - SAT_EN defined: `y_data`=0x7FFF.
  - SAT_EN undefined: the low 16 bits of (20·0x3FFF0001)>>>8.
- `start` and `x_wr_en` asserted mid-pass → no restart, x buffer unchanged, exactly 20 results.
- Reset low at E100 → after that edge `mem_ce0`=0 and `busy`=0, with no further `y_valid`. A fresh `start` then yields a complete, correct 20-row pass.
- Back-to-back passes (`start` the cycle after `done`) → 40 results total, with no stale accumulation carried across passes.
